// File: rtl/aq_ifu_fetch_seq.sv
// aq_ifu_fetch_seq: gates I-cache fetch on I-buf space and an outstanding budget,
// quiesces for lpmd/debug/reset-vector and pulses refetch on resume.
module aq_ifu_fetch_seq #(
    parameter int MAX_OUTSTD = 2
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic       cp0_ifu_lpmd_req,
    input  logic       cp0_ifu_in_lpmd,
    input  logic       rtu_ifu_dbg_mask,
    input  logic       vec_ctrl_reset_mask,
    input  logic       rtu_ifu_flush_fe,
    input  logic       ibuf_seq_inst_fetch,
    input  logic       icache_seq_req_acc,
    input  logic       icache_seq_resp_vld,
    output logic       seq_icache_req_vld,
    output logic       seq_cp0_lpmd_ack,
    output logic       seq_pcgen_refetch,
    output logic       seq_ifu_idle,
    output logic [2:0] seq_outstd_cnt
);
    typedef enum logic [2:0] {
        RESET   = 3'd0,
        FETCH   = 3'd1,
        DRAIN   = 3'd2,
        HALT    = 3'd3,
        RESTART = 3'd4
    } state_t;
    localparam logic [2:0] MAX = 3'(MAX_OUTSTD);
    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       stop, acc_q, resp_q;
    assign stop = cp0_ifu_lpmd_req | cp0_ifu_in_lpmd | rtu_ifu_dbg_mask | vec_ctrl_reset_mask;
    assign seq_icache_req_vld = (state == FETCH) & ibuf_seq_inst_fetch & !stop
                              & !rtu_ifu_flush_fe & (cnt < MAX);
    // an accept only counts against a live request; a response at zero is stale
    assign acc_q   = icache_seq_req_acc & seq_icache_req_vld;
    assign resp_q  = icache_seq_resp_vld & (cnt != 3'd0);
    assign cnt_nxt = cnt + {2'b00, acc_q} - {2'b00, resp_q};
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state <= RESET;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            RESET:   state_nxt = vec_ctrl_reset_mask ? RESET : FETCH;
            FETCH:   state_nxt = stop ? DRAIN : FETCH;
            DRAIN:   state_nxt = (cnt_nxt == 3'd0) ? HALT : DRAIN;
            HALT:    state_nxt = stop ? HALT : RESTART;
            RESTART: state_nxt = FETCH;
            default: state_nxt = RESET;
        endcase
    end
    assign seq_cp0_lpmd_ack  = (state == HALT);
    assign seq_pcgen_refetch = (state == RESTART);
    assign seq_ifu_idle      = (state == RESET) | (state == HALT);
    assign seq_outstd_cnt    = cnt;
endmodule

// File: tb/tb_aq_ifu_fetch_seq.sv
// tb_aq_ifu_fetch_seq: directed checks of reset release, budget, drain, resume, flush and reset.
module tb_aq_ifu_fetch_seq;
    logic       clk = 1'b0;
    logic       rst, lpmd, in_lpmd, dbg, vec, flush, ibuf, acc, resp;
    logic       req, ack, refetch, idle;
    logic [2:0] cnt;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    aq_ifu_fetch_seq #(.MAX_OUTSTD(2)) dut (
        .forever_cpuclk      (clk),
        .cpurst              (rst),
        .cp0_ifu_lpmd_req    (lpmd),
        .cp0_ifu_in_lpmd     (in_lpmd),
        .rtu_ifu_dbg_mask    (dbg),
        .vec_ctrl_reset_mask (vec),
        .rtu_ifu_flush_fe    (flush),
        .ibuf_seq_inst_fetch (ibuf),
        .icache_seq_req_acc  (acc),
        .icache_seq_resp_vld (resp),
        .seq_icache_req_vld  (req),
        .seq_cp0_lpmd_ack    (ack),
        .seq_pcgen_refetch   (refetch),
        .seq_ifu_idle        (idle),
        .seq_outstd_cnt      (cnt)
    );

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; vec = 1; ibuf = 1;
        lpmd = 0; in_lpmd = 0; dbg = 0; flush = 0; acc = 0; resp = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", {2'b0, req}, 0);
        chk("rst_ack", {2'b0, ack}, 0);
        chk("rst_refetch", {2'b0, refetch}, 0);
        chk("rst_idle", {2'b0, idle}, 1);
        chk("rst_cnt", cnt, 0);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("mask_idle", {2'b0, idle}, 1);
            chk("mask_req", {2'b0, req}, 0);
        end
        step(); vec = 0; #1;
        chk("mask_drop_still_reset", {2'b0, idle}, 1);
        step(); #1;
        chk("fetch_idle", {2'b0, idle}, 0);
        chk("fetch_req", {2'b0, req}, 1);
        chk("fetch_no_refetch", {2'b0, refetch}, 0);
        // budget: two accepts fill MAX_OUTSTD=2
        acc = 1;
        step(); #1;
        chk("bud_cnt1", cnt, 1);
        chk("bud_req1", {2'b0, req}, 1);
        step(); #1;
        chk("bud_cnt2", cnt, 2);
        chk("bud_full_req", {2'b0, req}, 0);
        step(); #1;
        chk("bud_acc_ignored", cnt, 2);
        acc = 0; resp = 1; #1;
        chk("bud_full_resp_req", {2'b0, req}, 0);
        step(); resp = 0; #1;
        chk("bud_after_resp_cnt", cnt, 1);
        chk("bud_after_resp_req", {2'b0, req}, 1);
        acc = 1; resp = 1;
        step(); acc = 0; resp = 0; #1;
        chk("bud_acc_resp_same", cnt, 1);
        acc = 1;
        step(); acc = 0; #1;
        chk("bud_refill", cnt, 2);
        // lpmd drain with two outstanding
        lpmd = 1; #1;
        chk("lpmd_req_drop", {2'b0, req}, 0);
        step(); in_lpmd = 1; #1;
        chk("lpmd_drain_idle", {2'b0, idle}, 0);
        chk("lpmd_drain_ack", {2'b0, ack}, 0);
        step();
        step(); resp = 1; #1;
        chk("lpmd_t3_ack", {2'b0, ack}, 0);
        step(); resp = 0; #1;
        chk("lpmd_t4_cnt", cnt, 1);
        chk("lpmd_t4_ack", {2'b0, ack}, 0);
        step();
        step(); resp = 1; #1;
        chk("lpmd_t6_ack", {2'b0, ack}, 0);
        step(); resp = 0; #1;
        chk("lpmd_t7_ack", {2'b0, ack}, 1);
        chk("lpmd_t7_idle", {2'b0, idle}, 1);
        chk("lpmd_t7_cnt", cnt, 0);
        lpmd = 0; in_lpmd = 0; #1;
        chk("lpmd_h_ack", {2'b0, ack}, 1);
        step(); #1;
        chk("lpmd_refetch", {2'b0, refetch}, 1);
        chk("lpmd_refetch_ack", {2'b0, ack}, 0);
        chk("lpmd_refetch_req", {2'b0, req}, 0);
        step(); #1;
        chk("lpmd_refetch_end", {2'b0, refetch}, 0);
        chk("lpmd_resume_req", {2'b0, req}, 1);
        // debug stop with nothing outstanding
        dbg = 1; #1;
        chk("dbg_req_drop", {2'b0, req}, 0);
        step(); #1;
        chk("dbg_drain_ack", {2'b0, ack}, 0);
        chk("dbg_drain_idle", {2'b0, idle}, 0);
        step(); #1;
        chk("dbg_halt_ack", {2'b0, ack}, 1);
        dbg = 0;
        step(); #1;
        chk("dbg_restart", {2'b0, refetch}, 1);
        step(); #1;
        chk("dbg_fetch_refetch", {2'b0, refetch}, 0);
        chk("dbg_fetch_req", {2'b0, req}, 1);
        // flush and stale responses
        flush = 1; acc = 1; #1;
        chk("flush_req", {2'b0, req}, 0);
        step(); flush = 0; acc = 0; #1;
        chk("flush_cnt", cnt, 0);
        chk("flush_one_cycle", {2'b0, req}, 1);
        resp = 1;
        step(); resp = 0; #1;
        chk("spurious_resp", cnt, 0);
        acc = 1;
        step(); acc = 0; #1;
        chk("flush_pre_cnt", cnt, 1);
        flush = 1;
        step(); flush = 0; #1;
        chk("flush_keeps_cnt", cnt, 1);
        dbg = 1;
        step(); dbg = 0; #1;
        chk("drain2_ack", {2'b0, ack}, 0);
        step(); #1;
        chk("drain2_not_aborted", {2'b0, idle}, 0);
        chk("drain2_no_refetch", {2'b0, refetch}, 0);
        resp = 1;
        step(); resp = 0; #1;
        chk("drain2_halt_ack", {2'b0, ack}, 1);
        chk("drain2_cnt", cnt, 0);
        step(); #1;
        chk("drain2_refetch", {2'b0, refetch}, 1);
        step(); #1;
        chk("drain2_req", {2'b0, req}, 1);
        // reset in the middle of a drain
        acc = 1;
        step(); #1;
        chk("rd_cnt1", cnt, 1);
        step(); acc = 0; #1;
        chk("rd_cnt2", cnt, 2);
        lpmd = 1;
        step(); #1;
        chk("rd_drain_ack", {2'b0, ack}, 0);
        chk("rd_drain_idle", {2'b0, idle}, 0);
        rst = 1; #1;
        chk("rd_cnt_clear", cnt, 0);
        chk("rd_ack", {2'b0, ack}, 0);
        chk("rd_idle", {2'b0, idle}, 1);
        lpmd = 0;
        step(); rst = 0; resp = 1; #1;
        chk("rd_resp_cnt", cnt, 0);
        step(); resp = 0; #1;
        chk("rd_post_resp_cnt", cnt, 0);
        chk("rd_fetch_req", {2'b0, req}, 1);
        chk("rd_no_refetch", {2'b0, refetch}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
